// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Streams one frame out of a byte-wide frame memory in raster order.
//   Reads are throttled so that the 2-entry output skid FIFO plus at most one
//   in-flight read never exceeds two pixels, which lets ready_i stall the
//   stream at any cycle without losing or duplicating a pixel.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start_i           1-cycle request to stream a frame (honoured in IDLE only)
//   ready_i           downstream accept; a pixel moves when we_o && ready_i
//   mem_rd_o          frame-memory read strobe
//   mem_addr_o        read address, row*WIDTH+col
//   mem_data_i        read data, valid the cycle after mem_rd_o
//   we_o              pixel valid (FIFO not empty)
//   data_o            pixel value
//   col_o, row_o      coordinates of the pixel on data_o
//   line_end_o        high with we_o on the last pixel of a line
//   busy_o            frame in progress
//   done_o            1-cycle pulse after the final pixel transfers
module pixel_stream_source #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      ready_i,
    output logic                      mem_rd_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [7:0]                mem_data_i,
    output logic                      we_o,
    output logic [7:0]                data_o,
    output logic [$clog2(WIDTH)-1:0]  col_o,
    output logic [$clog2(HEIGHT)-1:0] row_o,
    output logic                      line_end_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [CW-1:0]     rd_col;
    logic [RW-1:0]     rd_row;

    // One read can be outstanding; its coordinates travel with it.
    logic              inflight;
    logic [CW-1:0]     fl_col;
    logic [RW-1:0]     fl_row;

    // Skid FIFO: entry 0 is the head and drives the outputs.
    logic [7:0]        q_data [2];
    logic [CW-1:0]     q_col  [2];
    logic [RW-1:0]     q_row  [2];
    logic              q_le   [2];
    logic [1:0]        occ;

    logic              pop;
    logic              push;
    logic [1:0]        level;
    logic              new_le;

    assign pop    = we_o & ready_i;
    assign push   = inflight;
    assign new_le = (fl_col == LAST_COL);

    // Pixels that will be held after this edge if no new read is issued.
    // Counting this cycle's pop is what sustains 1 pixel/cycle with ready_i high.
    assign level = occ + {1'b0, inflight} - {1'b0, pop};

    assign mem_rd_o   = (state == FETCH) && (level < 2'd2);
    assign mem_addr_o = rd_addr;

    assign we_o       = (occ != 2'd0);
    assign data_o     = q_data[0];
    assign col_o      = q_col[0];
    assign row_o      = q_row[0];
    assign line_end_o = we_o & q_le[0];

    // Control FSM and read-side raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_col   <= '0;
            rd_row   <= '0;
            inflight <= 1'b0;
            fl_col   <= '0;
            fl_row   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            inflight <= mem_rd_o;
            if (mem_rd_o) begin
                fl_col <= rd_col;
                fl_row <= rd_row;
            end
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state   <= FETCH;
                        busy_o  <= 1'b1;
                        rd_addr <= '0;
                        rd_col  <= '0;
                        rd_row  <= '0;
                    end
                end
                FETCH: begin
                    if (mem_rd_o) begin
                        // Counters stop on the last address so mem_addr_o never runs past the frame.
                        if (rd_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            if (rd_col == LAST_COL) begin
                                rd_col <= '0;
                                rd_row <= rd_row + 1'b1;
                            end else begin
                                rd_col <= rd_col + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // level==0 already implies nothing is in flight or left after this pop.
                    if (level == 2'd0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output skid FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_data[i] <= '0;
                q_col[i]  <= '0;
                q_row[i]  <= '0;
                q_le[i]   <= 1'b0;
            end
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        q_data[0] <= mem_data_i;
                        q_col[0]  <= fl_col;
                        q_row[0]  <= fl_row;
                        q_le[0]   <= new_le;
                    end else begin
                        q_data[1] <= mem_data_i;
                        q_col[1]  <= fl_col;
                        q_row[1]  <= fl_row;
                        q_le[1]   <= new_le;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    q_data[0] <= q_data[1];
                    q_col[0]  <= q_col[1];
                    q_row[0]  <= q_row[1];
                    q_le[0]   <= q_le[1];
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new pixel lands behind whatever remains.
                    if (occ == 2'd1) begin
                        q_data[0] <= mem_data_i;
                        q_col[0]  <= fl_col;
                        q_row[0]  <= fl_row;
                        q_le[0]   <= new_le;
                    end else begin
                        q_data[0] <= q_data[1];
                        q_col[0]  <= q_col[1];
                        q_row[0]  <= q_row[1];
                        q_le[0]   <= q_le[1];
                        q_data[1] <= mem_data_i;
                        q_col[1]  <= fl_col;
                        q_row[1]  <= fl_row;
                        q_le[1]   <= new_le;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
